id_ex_operand_stage: RTL and testbench

ID/EX pipeline stage that sits directly upstream of the ALU. It captures one decoded instruction per transfer, resolves operand forwarding from the MEM and WB stages, and inserts load-use bubbles. It drives the ALU operand and control inputs, passes destination info downstream, and keeps a saturating stall counter for power modelling.

---
 rtl/id_ex_operand_stage.sv | 181 ++++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register sitting directly in front of the ALU. It holds one
// decoded instruction, resolves operand forwarding from the MEM and WB
// stages, inserts a bubble on a load-use hazard, and counts stalled cycles.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drop the held entry and any incoming beat
//   in_valid/in_ready   upstream handshake
//   in_*                decoded instruction fields
//   mem_*               MEM-stage forwarding source (loads never forward)
//   wb_*                WB-stage forwarding source
//   out_valid/out_ready downstream handshake
//   alu_A, alu_B        forwarded ALU operands
//   alu_ctrl            ALU operation
//   out_rd_addr         destination index passed downstream
//   out_reg_write       destination write enable, gated by out_valid
//   stall_count         saturating count of stalled cycles
// ---------------------------------------------------------------------------
package id_ex_operand_stage_pkg;
  localparam int RISC_V_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ALU_AND = 2'd0,
    ALU_OR  = 2'd1,
    ALU_ADD = 2'd2,
    ALU_SUB = 2'd3
  } ALU_ctrl_t;
endpackage

module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [REG_ADDR_WIDTH-1:0]    in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0]    in_rs2_addr,
  input  logic [RISC_V_DATA_WIDTH-1:0] in_rs1_data,
  input  logic [RISC_V_DATA_WIDTH-1:0] in_rs2_data,
  input  logic [RISC_V_DATA_WIDTH-1:0] in_imm,
  input  logic                         in_use_imm,
  input  logic [REG_ADDR_WIDTH-1:0]    in_rd_addr,
  input  logic                         in_reg_write,
  input  ALU_ctrl_t                    in_ALU_ctrl,
  input  logic [REG_ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic                         mem_reg_write,
  input  logic                         mem_is_load,
  input  logic [RISC_V_DATA_WIDTH-1:0] mem_data,
  input  logic [REG_ADDR_WIDTH-1:0]    wb_rd_addr,
  input  logic                         wb_reg_write,
  input  logic [RISC_V_DATA_WIDTH-1:0] wb_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RISC_V_DATA_WIDTH-1:0] alu_A,
  output logic [RISC_V_DATA_WIDTH-1:0] alu_B,
  output ALU_ctrl_t                    alu_ctrl,
  output logic [REG_ADDR_WIDTH-1:0]    out_rd_addr,
  output logic                         out_reg_write,
  output logic [STALL_CNT_WIDTH-1:0]   stall_count
);

  localparam int DW = RISC_V_DATA_WIDTH;
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = 1;

  // Held entry
  logic                      valid_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic [DW-1:0]             rs1_q, rs2_q, imm_q;
  logic                      use_imm_q, reg_write_q;
  ALU_ctrl_t                 ctrl_q;
  logic [STALL_CNT_WIDTH-1:0] stall_q;

  logic [DW-1:0] rs1_fwd, rs2_fwd;
  logic          hazard;
  logic          xfer_out;
  logic          capture;
  logic          stall_inc;

  // Operand resolution: x0 is hard zero, then MEM (ALU results only, a load's
  // data is not available yet), then WB, then the held copy.
  function automatic logic [DW-1:0] fwd(
    input logic [REG_ADDR_WIDTH-1:0] idx,
    input logic [DW-1:0]             stored,
    input logic [REG_ADDR_WIDTH-1:0] m_addr,
    input logic                      m_we,
    input logic                      m_load,
    input logic [DW-1:0]             m_data,
    input logic [REG_ADDR_WIDTH-1:0] w_addr,
    input logic                      w_we,
    input logic [DW-1:0]             w_data
  );
    logic [DW-1:0] res;
    res = stored;
    if (idx == '0)                                 res = '0;
    else if (m_we && !m_load && (m_addr == idx))   res = m_data;
    else if (w_we && (w_addr == idx))              res = w_data;
    return res;
  endfunction

  always_comb begin
    rs1_fwd = fwd(rs1_addr_q, rs1_q, mem_rd_addr, mem_reg_write, mem_is_load,
                  mem_data, wb_rd_addr, wb_reg_write, wb_data);
    rs2_fwd = fwd(rs2_addr_q, rs2_q, mem_rd_addr, mem_reg_write, mem_is_load,
                  mem_data, wb_rd_addr, wb_reg_write, wb_data);
  end

  // A load in MEM targeting a source we actually read must wait one cycle so
  // its data can be picked up from WB. rs2 is ignored when B is the immediate.
  always_comb begin
    hazard = valid_q && mem_reg_write && mem_is_load && (mem_rd_addr != '0) &&
             ((mem_rd_addr == rs1_addr_q) ||
              (!use_imm_q && (mem_rd_addr == rs2_addr_q)));
  end

  // Handshake: a beat moves on any rising edge where valid and ready are both
  // high in that cycle. Valid never depends on ready; ready may depend on
  // valid. Flush makes in_ready 1 so the incoming beat is consumed and dropped.
  assign out_valid = valid_q && !hazard;
  assign xfer_out  = out_valid && out_ready;
  assign in_ready  = flush || !valid_q || xfer_out;
  assign capture   = in_valid && in_ready && !flush;
  assign stall_inc = valid_q && !flush && (hazard || (out_valid && !out_ready));

  assign alu_A         = rs1_fwd;
  assign alu_B         = use_imm_q ? imm_q : rs2_fwd;
  assign alu_ctrl      = ctrl_q;
  assign out_rd_addr   = rd_addr_q;
  assign out_reg_write = reg_write_q && out_valid;
  assign stall_count   = stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      ctrl_q      <= ALU_ADD;
      stall_q     <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (capture) begin
        valid_q     <= 1'b1;
        rs1_addr_q  <= in_rs1_addr;
        rs2_addr_q  <= in_rs2_addr;
        rd_addr_q   <= in_rd_addr;
        rs1_q       <= in_rs1_data;
        rs2_q       <= in_rs2_data;
        imm_q       <= in_imm;
        use_imm_q   <= in_use_imm;
        reg_write_q <= in_reg_write;
        ctrl_q      <= in_ALU_ctrl;
      end else if (xfer_out) begin
        valid_q <= 1'b0;
      end else if (valid_q) begin
        // Held entry: latch forwarded values so a result that retires past
        // WB while we wait is not lost.
        rs1_q <= rs1_fwd;
        rs2_q <= rs2_fwd;
      end

      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + STALL_ONE;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  localparam int AW = 5;
  localparam int SW = 4;   // narrow counter so saturation is reachable
  localparam int DW = RISC_V_DATA_WIDTH;
  localparam int STALL_MAX = (1 << SW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          flush, in_valid, in_ready;
  logic [AW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [DW-1:0] in_rs1_data, in_rs2_data, in_imm;
  logic          in_use_imm, in_reg_write;
  ALU_ctrl_t     in_ALU_ctrl;
  logic [AW-1:0] mem_rd_addr, wb_rd_addr;
  logic          mem_reg_write, mem_is_load, wb_reg_write;
  logic [DW-1:0] mem_data, wb_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] alu_A, alu_B;
  ALU_ctrl_t     alu_ctrl;
  logic [AW-1:0] out_rd_addr;
  logic          out_reg_write;
  logic [SW-1:0] stall_count;

  id_ex_operand_stage #(.REG_ADDR_WIDTH(AW), .STALL_CNT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .in_ALU_ctrl(in_ALU_ctrl),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_is_load(mem_is_load), .mem_data(mem_data),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ctrl(alu_ctrl),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
    .stall_count(stall_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One slot holding the instruction as it was issued plus whatever operand
  // values it has been refreshed with while waiting.
  logic          m_valid;
  logic [AW-1:0] m_a1, m_a2, m_rd;
  logic [DW-1:0] m_d1, m_d2, m_imm;
  logic          m_ui, m_rw;
  ALU_ctrl_t     m_ctrl;
  int            m_stall;

  function automatic logic [DW-1:0] operand(input logic [AW-1:0] idx, input logic [DW-1:0] held);
    if (idx == 0) return '0;
    if (mem_reg_write && !mem_is_load && mem_rd_addr == idx) return mem_data;
    if (wb_reg_write && wb_rd_addr == idx) return wb_data;
    return held;
  endfunction

  function automatic logic load_use();
    logic reads;
    reads = (mem_rd_addr == m_a1) || (!m_ui && mem_rd_addr == m_a2);
    return m_valid && mem_reg_write && mem_is_load && mem_rd_addr != 0 && reads;
  endfunction

  function automatic logic exp_out_valid();
    return m_valid && !load_use();
  endfunction

  function automatic logic exp_in_ready();
    return flush || !m_valid || (exp_out_valid() && out_ready);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_valid = 0; m_a1 = 0; m_a2 = 0; m_rd = 0; m_d1 = 0; m_d2 = 0;
        m_imm = 0; m_ui = 0; m_rw = 0; m_ctrl = ALU_ADD; m_stall = 0;
      end else begin
        logic ov, rdy, sent;
        logic [DW-1:0] n1, n2;
        ov   = exp_out_valid();
        rdy  = exp_in_ready();
        sent = ov && out_ready;
        n1   = operand(m_a1, m_d1);
        n2   = operand(m_a2, m_d2);
        if (m_valid && !flush && !sent && m_stall < STALL_MAX) m_stall++;
        if (flush) m_valid = 0;
        else if (in_valid && rdy) begin
          m_valid = 1; m_a1 = in_rs1_addr; m_a2 = in_rs2_addr; m_rd = in_rd_addr;
          m_d1 = in_rs1_data; m_d2 = in_rs2_data; m_imm = in_imm;
          m_ui = in_use_imm; m_rw = in_reg_write; m_ctrl = in_ALU_ctrl;
        end else if (sent) m_valid = 0;
        else if (m_valid) begin
          m_d1 = n1; m_d2 = n2;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_out_valid", 32'(out_valid), 32'(exp_out_valid()));
      chk("cmp_in_ready", 32'(in_ready), 32'(exp_in_ready()));
      chk("cmp_stall", 32'(stall_count), 32'(m_stall));
      if (m_valid) begin
        chk("cmp_alu_A", alu_A, operand(m_a1, m_d1));
        chk("cmp_alu_B", alu_B, m_ui ? m_imm : operand(m_a2, m_d2));
        chk("cmp_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
        chk("cmp_rd", 32'(out_rd_addr), 32'(m_rd));
        chk("cmp_rw", 32'(out_reg_write), 32'(m_rw && exp_out_valid()));
      end else begin
        chk("cmp_rw_idle", 32'(out_reg_write), 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; out_ready = 1;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_use_imm = 0; in_reg_write = 0; in_ALU_ctrl = ALU_ADD;
    mem_rd_addr = 0; mem_reg_write = 0; mem_is_load = 0; mem_data = 0;
    wb_rd_addr = 0; wb_reg_write = 0; wb_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic beat(input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                      input logic [DW-1:0] imm, input logic ui,
                      input logic [AW-1:0] rd, input logic rw, input ALU_ctrl_t c);
    in_valid = 1;
    in_rs1_addr = a1; in_rs1_data = d1;
    in_rs2_addr = a2; in_rs2_data = d2;
    in_imm = imm; in_use_imm = ui;
    in_rd_addr = rd; in_reg_write = rw; in_ALU_ctrl = c;
  endtask

  // back-to-back stream: rs1, rs2, WB-forward target, WB data
  logic [AW-1:0] t_a1 [4] = '{5'd1, 5'd2, 5'd3, 5'd0};
  logic [AW-1:0] t_a2 [4] = '{5'd9, 5'd3, 5'd0, 5'd2};
  logic [AW-1:0] t_wb [4] = '{5'd9, 5'd2, 5'd7, 5'd2};
  logic [DW-1:0] t_wd [4] = '{32'h900, 32'h200, 32'h700, 32'h222};
  ALU_ctrl_t     t_c  [4] = '{ALU_AND, ALU_OR, ALU_SUB, ALU_ADD};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_alu_A", alu_A, 32'h0);
    chk("rst_alu_B", alu_B, 32'h0);
    chk("rst_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
    chk("rst_stall", 32'(stall_count), 32'h0);
    rst_n = 1;

    // basic transfer
    beat(5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 1'b0, 5'd10, 1'b1, ALU_ADD);
    step();
    in_valid = 0;
    @(negedge clk);
    chk("basic_valid", 32'(out_valid), 32'h1);
    chk("basic_A", alu_A, 32'd5);
    chk("basic_B", alu_B, 32'd7);
    chk("basic_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
    chk("basic_rd", 32'(out_rd_addr), 32'd10);
    step();

    // forwarding priority
    do_reset();
    out_ready = 0;
    beat(5'd3, 32'hAA, 5'd8, 32'hBB, 32'h0, 1'b0, 5'd11, 1'b1, ALU_SUB);
    step();
    in_valid = 0;
    mem_reg_write = 1; mem_rd_addr = 5'd3; mem_is_load = 0; mem_data = 32'h10;
    wb_reg_write = 1; wb_rd_addr = 5'd3; wb_data = 32'h20;
    @(negedge clk);
    chk("fwd_mem_over_wb", alu_A, 32'h10);
    step();
    mem_reg_write = 0;
    @(negedge clk);
    chk("fwd_wb", alu_A, 32'h20);
    step();
    wb_reg_write = 0;
    @(negedge clk);
    chk("fwd_refreshed", alu_A, 32'h20);
    out_ready = 1;
    beat(5'd0, 32'h77, 5'd0, 32'h0, 32'h5, 1'b1, 5'd12, 1'b1, ALU_OR);
    step();
    in_valid = 0;
    mem_reg_write = 1; mem_rd_addr = 5'd0; mem_data = 32'h33;
    @(negedge clk);
    chk("fwd_x0", alu_A, 32'h0);
    step();
    mem_reg_write = 0;

    // load-use
    do_reset();
    beat(5'd5, 32'h1, 5'd4, 32'h11, 32'h0, 1'b0, 5'd13, 1'b1, ALU_ADD);
    step();
    in_valid = 0;
    mem_reg_write = 1; mem_is_load = 1; mem_rd_addr = 5'd4; mem_data = 32'hDEAD;
    @(negedge clk);
    chk("lu_valid", 32'(out_valid), 32'h0);
    chk("lu_ready", 32'(in_ready), 32'h0);
    step();
    mem_reg_write = 0; mem_is_load = 0;
    wb_reg_write = 1; wb_rd_addr = 5'd4; wb_data = 32'h55;
    @(negedge clk);
    chk("lu_stall", 32'(stall_count), 32'h1);
    chk("lu_release", 32'(out_valid), 32'h1);
    chk("lu_B", alu_B, 32'h55);
    step();
    wb_reg_write = 0;

    // load-use on rs2 ignored when B is the immediate
    do_reset();
    beat(5'd5, 32'h1, 5'd4, 32'h11, 32'h123, 1'b1, 5'd13, 1'b1, ALU_ADD);
    step();
    in_valid = 0;
    mem_reg_write = 1; mem_is_load = 1; mem_rd_addr = 5'd4;
    @(negedge clk);
    chk("imm_no_stall", 32'(out_valid), 32'h1);
    chk("imm_B", alu_B, 32'h123);
    step();
    mem_reg_write = 0; mem_is_load = 0;
    @(negedge clk);
    chk("imm_stall_cnt", 32'(stall_count), 32'h0);

    // backpressure refresh
    do_reset();
    beat(5'd6, 32'h1, 5'd0, 32'h0, 32'h0, 1'b0, 5'd14, 1'b1, ALU_AND);
    step();
    in_valid = 0; out_ready = 0;
    wb_reg_write = 1; wb_rd_addr = 5'd6; wb_data = 32'h99;
    step();
    wb_reg_write = 0;
    step();
    step();
    out_ready = 1;
    @(negedge clk);
    chk("bp_A", alu_A, 32'h99);
    chk("bp_stall", 32'(stall_count), 32'h3);
    step();

    // flush with incoming beat
    do_reset();
    out_ready = 0;
    beat(5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0, 5'd7, 1'b1, ALU_ADD);
    step();
    flush = 1;
    beat(5'd3, 32'h3, 5'd4, 32'h4, 32'h0, 1'b0, 5'd9, 1'b1, ALU_SUB);
    @(negedge clk);
    chk("flush_ready", 32'(in_ready), 32'h1);
    step();
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_stall", 32'(stall_count), 32'h0);
    out_ready = 1;

    // back-to-back stream with WB forwarding
    do_reset();
    for (int i = 0; i < 4; i++) begin
      beat(t_a1[i], 32'(i + 1), t_a2[i], 32'(i + 16), 32'h0, 1'b0, 5'(i + 20), 1'b1, t_c[i]);
      wb_reg_write = 1; wb_rd_addr = t_wb[i]; wb_data = t_wd[i];
      step();
    end
    in_valid = 0;
    @(negedge clk);
    chk("stream_B", alu_B, 32'h222);
    step();
    wb_reg_write = 0;

    // saturation
    do_reset();
    beat(5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0, 5'd1, 1'b0, ALU_OR);
    step();
    in_valid = 0; out_ready = 0;
    repeat (20) step();
    @(negedge clk);
    chk("sat_stall", 32'(stall_count), 32'(STALL_MAX));
    out_ready = 1;
    step();

    // asynchronous reset mid-stall
    do_reset();
    beat(5'd3, 32'h44, 5'd4, 32'h66, 32'h0, 1'b0, 5'd15, 1'b1, ALU_SUB);
    step();
    in_valid = 0; out_ready = 0;
    step();
    step();
    #2;
    rst_n = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_ready", 32'(in_ready), 32'h1);
    chk("arst_A", alu_A, 32'h0);
    chk("arst_B", alu_B, 32'h0);
    chk("arst_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
    chk("arst_rd", 32'(out_rd_addr), 32'h0);
    chk("arst_rw", 32'(out_reg_write), 32'h0);
    chk("arst_stall", 32'(stall_count), 32'h0);
    step();
    rst_n = 1;
    out_ready = 1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
